// File: rtl/mastermind_pkg.sv
// Shared Mastermind definitions: peg encodings, colour width and the scorer FSM state type.
package mastermind_pkg;

  localparam int COLOR_W = 3;

  localparam logic [1:0] PEG_NONE  = 2'b00;
  localparam logic [1:0] PEG_WHITE = 2'b01;
  localparam logic [1:0] PEG_BLACK = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    EXACT,
    PARTIAL,
    DONE
  } state_t;

endpackage

// File: rtl/peg_packer.sv
// Packs black/white counts into a position-free peg vector (blacks first, then whites).
// Only built with FEEDBACK_SORTED_EN, the one configuration that instantiates it.
`ifdef FEEDBACK_SORTED_EN
module peg_packer
  import mastermind_pkg::*;
(
  input  logic [2:0] blacks,
  input  logic [2:0] whites,
  output logic [7:0] pegs
);

  logic [2:0] marked;

  always_comb begin
    marked = blacks + whites;
    pegs   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < blacks)      pegs[2*i +: 2] = PEG_BLACK;
      else if (3'(i) < marked) pegs[2*i +: 2] = PEG_WHITE;
      else                     pegs[2*i +: 2] = PEG_NONE;
    end
  end

endmodule
`endif

// File: rtl/feedback_scorer.sv
// Sequential Mastermind scorer: 4-cycle exact pass, 16-cycle pairwise colour pass, one publish cycle.
// Define FEEDBACK_SORTED_EN to report pegs packed (blacks first) instead of per guess slot.
module feedback_scorer
  import mastermind_pkg::*;
#(
  parameter int COLOR_W   = mastermind_pkg::COLOR_W,
  parameter int MAX_TURNS = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               new_game,
  input  logic [COLOR_W-1:0]                 code0,
  input  logic [COLOR_W-1:0]                 code1,
  input  logic [COLOR_W-1:0]                 code2,
  input  logic [COLOR_W-1:0]                 code3,
  input  logic [COLOR_W-1:0]                 guess0,
  input  logic [COLOR_W-1:0]                 guess1,
  input  logic [COLOR_W-1:0]                 guess2,
  input  logic [COLOR_W-1:0]                 guess3,
  output logic [1:0]                         peg0,
  output logic [1:0]                         peg1,
  output logic [1:0]                         peg2,
  output logic [1:0]                         peg3,
  output logic [2:0]                         blacks,
  output logic [2:0]                         whites,
  output logic                               busy,
  output logic                               done,
  output logic                               win,
  output logic                               game_over,
  output logic [$clog2(MAX_TURNS+1)-1:0]     turn_count
);

  localparam int              TC_W   = $clog2(MAX_TURNS+1);
  localparam logic [TC_W-1:0] TC_MAX = TC_W'(MAX_TURNS);

  state_t             state;
  logic [COLOR_W-1:0] c [4];
  logic [COLOR_W-1:0] g [4];
  logic [3:0]         gm, cm;
  logic [1:0]         slot_peg [4];
  logic [2:0]         b_acc, w_acc;
  logic [3:0]         idx;
  logic [1:0]         pi, pj;
  logic [TC_W-1:0]    tc_next;
  logic [7:0]         packed_pegs;

  always_comb begin
    pi      = idx[3:2];
    pj      = idx[1:0];
    tc_next = (turn_count == TC_MAX) ? turn_count : turn_count + 1'b1;
  end

`ifdef FEEDBACK_SORTED_EN
  peg_packer u_peg_packer (
    .blacks (b_acc),
    .whites (w_acc),
    .pegs   (packed_pegs)
  );
`else
  always_comb packed_pegs = {slot_peg[3], slot_peg[2], slot_peg[1], slot_peg[0]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      c          <= '{default: '0};
      g          <= '{default: '0};
      gm         <= '0;
      cm         <= '0;
      slot_peg   <= '{default: PEG_NONE};
      b_acc      <= '0;
      w_acc      <= '0;
      {peg3, peg2, peg1, peg0} <= '0;
      blacks     <= '0;
      whites     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win        <= 1'b0;
      game_over  <= 1'b0;
      turn_count <= '0;
    end else if (new_game) begin
      state      <= IDLE;
      idx        <= '0;
      c          <= '{default: '0};
      g          <= '{default: '0};
      gm         <= '0;
      cm         <= '0;
      slot_peg   <= '{default: PEG_NONE};
      b_acc      <= '0;
      w_acc      <= '0;
      {peg3, peg2, peg1, peg0} <= '0;
      blacks     <= '0;
      whites     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win        <= 1'b0;
      game_over  <= 1'b0;
      turn_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !game_over) begin
            c        <= '{code0, code1, code2, code3};
            g        <= '{guess0, guess1, guess2, guess3};
            gm       <= '0;
            cm       <= '0;
            slot_peg <= '{default: PEG_NONE};
            b_acc    <= '0;
            w_acc    <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= EXACT;
          end
        end
        EXACT: begin
          if (g[pj] == c[pj]) begin
            gm[pj]       <= 1'b1;
            cm[pj]       <= 1'b1;
            slot_peg[pj] <= PEG_BLACK;
            b_acc        <= b_acc + 3'd1;
          end
          if (idx == 4'd3) begin
            idx   <= '0;
            state <= PARTIAL;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        PARTIAL: begin
          // A white hit sets gm[pi], which also blocks any later j for the same guess slot.
          if (!gm[pi] && !cm[pj] && (g[pi] == c[pj])) begin
            gm[pi]       <= 1'b1;
            cm[pj]       <= 1'b1;
            slot_peg[pi] <= PEG_WHITE;
            w_acc        <= w_acc + 3'd1;
          end
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= DONE;
        end
        DONE: begin
          {peg3, peg2, peg1, peg0} <= packed_pegs;
          blacks     <= b_acc;
          whites     <= w_acc;
          done       <= 1'b1;
          turn_count <= tc_next;
          win        <= (b_acc == 3'd4);
          game_over  <= (b_acc == 3'd4) || (tc_next == TC_MAX);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feedback_scorer.sv
// Scoreboard bench for feedback_scorer: expected scores queued at start, compared at done.
module tb_feedback_scorer;

  logic       clk = 1'b0;
  logic       reset, start, new_game;
  logic [2:0] code0, code1, code2, code3;
  logic [2:0] guess0, guess1, guess2, guess3;
  logic [1:0] peg0, peg1, peg2, peg3;
  logic [2:0] blacks, whites;
  logic       busy, done, win, game_over;
  logic [3:0] turn_count;

  typedef struct {
    logic [2:0] b;
    logic [2:0] w;
    logic [7:0] pegs;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   exp_turns = 0;

  always #5 clk = ~clk;

  feedback_scorer #(.COLOR_W(3), .MAX_TURNS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .new_game(new_game),
    .code0(code0), .code1(code1), .code2(code2), .code3(code3),
    .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .peg0(peg0), .peg1(peg1), .peg2(peg2), .peg3(peg3),
    .blacks(blacks), .whites(whites), .busy(busy), .done(done),
    .win(win), .game_over(game_over), .turn_count(turn_count)
  );

  function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Counts from colour histograms; per-slot pegs from blacks-then-first-free-code-slot assignment.
  function automatic exp_t model(input logic [11:0] cv, input logic [11:0] gv);
    exp_t       e;
    logic [2:0] cc[4];
    logic [2:0] gg[4];
    logic [3:0] uc, ug;
    int         hc[8];
    int         hg[8];
    int         nb, total;
    for (int k = 0; k < 8; k++) begin hc[k] = 0; hg[k] = 0; end
    for (int i = 0; i < 4; i++) begin
      cc[i] = cv[3*i +: 3];
      gg[i] = gv[3*i +: 3];
      hc[cc[i]]++;
      hg[gg[i]]++;
    end
    e.pegs = '0; uc = '0; ug = '0; nb = 0; total = 0;
    for (int i = 0; i < 4; i++)
      if (gg[i] == cc[i]) begin
        e.pegs[2*i +: 2] = 2'b10; uc[i] = 1'b1; ug[i] = 1'b1; nb++;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!ug[i] && !uc[j] && gg[i] == cc[j]) begin
          e.pegs[2*i +: 2] = 2'b01; uc[j] = 1'b1; ug[i] = 1'b1;
        end
    for (int k = 0; k < 8; k++) total += (hc[k] < hg[k]) ? hc[k] : hg[k];
    e.b = 3'(nb);
    e.w = 3'(total - nb);
`ifdef FEEDBACK_SORTED_EN
    for (int i = 0; i < 4; i++)
      e.pegs[2*i +: 2] = (i < nb) ? 2'b10 : (i < total) ? 2'b01 : 2'b00;
`endif
    return e;
  endfunction

  task automatic set_inputs(input logic [11:0] cv, input logic [11:0] gv);
    {code3, code2, code1, code0}     = cv;
    {guess3, guess2, guess1, guess0} = gv;
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game  = 1'b0;
    exp_turns = 0;
  endtask

  task automatic score(input string name, input logic [11:0] cv, input logic [11:0] gv);
    exp_t e;
    int   cyc;
    sb.push_back(model(cv, gv));
    set_inputs(cv, gv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_inputs(12'($urandom), 12'($urandom));
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy after start: got %b want 1", name, busy); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != 21) begin errors++; $display("FAIL %s latency: got %0d want 21", name, cyc); end
    e = sb.pop_front();
    exp_turns = (exp_turns < 8) ? exp_turns + 1 : 8;
    checks++;
    if (blacks !== e.b) begin errors++; $display("FAIL %s blacks: got %0d want %0d", name, blacks, e.b); end
    checks++;
    if (whites !== e.w) begin errors++; $display("FAIL %s whites: got %0d want %0d", name, whites, e.w); end
    checks++;
    if ({peg3, peg2, peg1, peg0} !== e.pegs) begin
      errors++; $display("FAIL %s pegs3..0: got %b want %b", name, {peg3, peg2, peg1, peg0}, e.pegs);
    end
    checks++;
    if (turn_count !== 4'(exp_turns)) begin errors++; $display("FAIL %s turn_count: got %0d want %0d", name, turn_count, exp_turns); end
    checks++;
    if ({win, game_over} !== {e.b == 3'd4, (e.b == 3'd4) || exp_turns == 8}) begin
      errors++; $display("FAIL %s win/game_over: got %b%b want %b%b", name, win, game_over, e.b == 3'd4, (e.b == 3'd4) || exp_turns == 8);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL %s done/busy after pulse: got %b want 00", name, {done, busy}); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; new_game = 1'b0;
    set_inputs('0, '0);
    repeat (3) @(negedge clk);
    checks++;
    if ({peg3, peg2, peg1, peg0, blacks, whites, busy, done, win, game_over, turn_count} !== '0) begin
      errors++; $display("FAIL reset outputs: got %h want 0", {peg3, peg2, peg1, peg0, blacks, whites, busy, done, win, game_over, turn_count});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact_win();
    score("exact_win", pk(1, 2, 3, 4), pk(1, 2, 3, 4));
    checks++;
    if ({blacks, whites, peg3, peg2, peg1, peg0, win, game_over, turn_count} !== {3'd4, 3'd0, 8'b10101010, 2'b11, 4'd1}) begin
      errors++; $display("FAIL exact_win fixed result: got %h", {blacks, whites, peg3, peg2, peg1, peg0, win, game_over, turn_count});
    end
  endtask

  task automatic test_duplicates();
    do_new_game();
    score("duplicates", pk(1, 1, 2, 3), pk(1, 2, 1, 1));
    checks++;
    if ({blacks, whites, peg3, peg2, peg1, peg0} !== {3'd1, 3'd2, 8'b00010110}) begin
      errors++; $display("FAIL duplicates fixed result: got %h", {blacks, whites, peg3, peg2, peg1, peg0});
    end
  endtask

  task automatic test_all_white();
    score("all_white", pk(3, 2, 1, 0), pk(0, 1, 2, 3));
    checks++;
    if ({blacks, whites, peg3, peg2, peg1, peg0} !== {3'd0, 3'd4, 8'b01010101}) begin
      errors++; $display("FAIL all_white fixed result: got %h", {blacks, whites, peg3, peg2, peg1, peg0});
    end
  endtask

  task automatic test_random();
    logic [11:0] cv, gv;
    for (int n = 0; n < 4; n++) begin
      cv = 12'($urandom);
      gv = 12'($urandom);
      if (gv == cv) gv[2:0] = gv[2:0] + 3'd1;
      score("random", cv, gv);
    end
  endtask

  task automatic test_turn_limit();
    logic saw_busy, saw_done;
    do_new_game();
    for (int n = 0; n < 8; n++) score("turn_limit", pk(0, 1, 2, 3), pk(4, 4, 4, 4));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_busy = busy; saw_done = done;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      saw_busy |= busy; saw_done |= done;
    end
    checks++;
    if ({saw_busy, saw_done} !== 2'b00) begin errors++; $display("FAIL ninth_start busy/done seen: got %b want 00", {saw_busy, saw_done}); end
    checks++;
    if ({game_over, turn_count} !== {1'b1, 4'd8}) begin
      errors++; $display("FAIL ninth_start game_over/turns: got %b/%0d want 1/8", game_over, turn_count);
    end
  endtask

  task automatic test_new_game_abort();
    logic seen;
    do_new_game();
    score("pre_abort", pk(1, 1, 2, 3), pk(1, 2, 1, 1));
    set_inputs(pk(1, 2, 3, 4), pk(1, 2, 3, 4));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    new_game = 1'b1; start = 1'b1;
    @(negedge clk);
    new_game = 1'b0; start = 1'b0; exp_turns = 0;
    checks++;
    if ({peg3, peg2, peg1, peg0, blacks, whites, busy, done, win, game_over, turn_count} !== '0) begin
      errors++; $display("FAIL abort outputs: got %h want 0", {peg3, peg2, peg1, peg0, blacks, whites, busy, done, win, game_over, turn_count});
    end
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin @(negedge clk); seen |= done | busy; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort activity after new_game: got %b want 0", seen); end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    int         ndone, done_cyc;
    logic [2:0] got_b, got_w;
    logic [3:0] turns_before;
    turns_before = turn_count;
    sb.push_back(model(pk(5, 6, 7, 0), pk(6, 6, 0, 7)));
    set_inputs(pk(5, 6, 7, 0), pk(6, 6, 0, 7));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; done_cyc = 0; got_b = '0; got_w = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 4 || k == 12) begin
        set_inputs(pk(1, 1, 1, 1), pk(1, 1, 1, 1));
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin done_cyc = k; got_b = blacks; got_w = whites; end
      end
    end
    e = sb.pop_front();
    exp_turns++;
    checks++;
    if (ndone != 1 || done_cyc != 21) begin
      errors++; $display("FAIL back_to_back done count/cycle: got %0d/%0d want 1/21", ndone, done_cyc);
    end
    checks++;
    if ({got_b, got_w} !== {e.b, e.w}) begin
      errors++; $display("FAIL back_to_back score: got %0d/%0d want %0d/%0d", got_b, got_w, e.b, e.w);
    end
    checks++;
    if (turn_count !== turns_before + 4'd1) begin
      errors++; $display("FAIL back_to_back turn_count: got %0d want %0d", turn_count, turns_before + 4'd1);
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    set_inputs(pk(2, 2, 3, 3), pk(2, 3, 2, 3));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({peg3, peg2, peg1, peg0, blacks, whites, busy, done, win, game_over, turn_count} !== '0) begin
      errors++; $display("FAIL async_reset outputs: got %h want 0", {peg3, peg2, peg1, peg0, blacks, whites, busy, done, win, game_over, turn_count});
    end
    @(negedge clk);
    reset = 1'b1; exp_turns = 0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin @(negedge clk); seen |= done | busy; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL async_reset activity after reset: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_exact_win();
    test_duplicates();
    test_all_white();
    test_random();
    test_turn_limit();
    test_new_game_abort();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/feedback_scorer.md
# feedback_scorer

Sequential Mastermind scoring stage. It sits between `history` (which supplies the committed guess) and the seven-segment converters, and uses the secret code from `prng`. On a `start` pulse it captures code and guess and computes exact (black) and colour-only (white) matches over a fixed-length scan. It then publishes per-position peg values and counts, and tracks turns, win and game over.

## Interface
Parameters:
- `COLOR_W`, 3: width of one colour index.
- `MAX_TURNS`, 8: scored guesses allowed before game over (matches the 8 turn LEDs).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: score request; sampled only in IDLE.
- `new_game` in 1: clears turns and results; aborts any scan in progress.
- `code0..code3` in COLOR_W each: secret code.
- `guess0..guess3` in COLOR_W each: guess to score.
- `peg0..peg3` out 2 each: per-slot feedback; 00 none, 01 white, 10 black; 11 never driven.
- `blacks` out 3: exact-match count, 0..4.
- `whites` out 3: colour-only count, 0..4.
- `busy` out 1: high while a scan is in progress.
- `done` out 1: one-cycle pulse when results update.
- `win` out 1: set when the last score is 4 blacks.
- `game_over` out 1: `win`, or turn count equal to `MAX_TURNS`.
- `turn_count` out $clog2(MAX_TURNS+1): number of scored guesses.

## Operation
- FSM states are IDLE, EXACT, PARTIAL, DONE.
- IDLE to EXACT: `start` is high, `new_game` is low and `game_over` is low. On that edge, code and guess are captured into internal registers. Later input changes do not affect the scan.
- EXACT, index i=0..3, one per cycle: if `g[i]==c[i]`, set `gm[i]` and `cm[i]`, mark slot i black, and increment the black accumulator.
- PARTIAL, pair (i,j) visited i-major over 0..3 × 0..3, one per cycle, always 16 cycles. A pair counts as a white when all of these hold:
  - `!gm[i]` and `!cm[j]`;
  - `g[i]==c[j]`;
  - no white has yet been found for i in this pass.
  - On a hit: set `gm[i]` and `cm[j]`, mark slot i white, increment the white accumulator.
- Duplicate colours are therefore never counted twice.
- DONE (one cycle), then return to IDLE:
  - publish `peg*`, `blacks` and `whites`;
  - pulse `done`;
  - increment `turn_count`, saturating at `MAX_TURNS`;
  - set `win` if blacks==4;
  - `game_over` then follows its definition.
- `start` outside IDLE, or while `game_over` is high, is ignored. It is not queued.
- `new_game` in any state, on the next edge:
  - FSM goes to IDLE;
  - all outputs and counters clear to 0;
  - no `done` pulse is issued.
- `new_game` and `start` high on the same edge: `new_game` wins.
- Accumulators are 3 bits and cannot overflow, since blacks+whites ≤ 4.

## Timing
- Reset values: every output is 0, state is IDLE, and the captured registers and match flags are 0.
- Asserting `reset` at any time aborts the scan immediately (asynchronously).
- `start` sampled at edge E0:
  - `busy` is high from E0 to E21;
  - EXACT occupies E1..E4;
  - PARTIAL occupies E5..E20;
  - DONE is entered at E20;
  - results, `done`=1, `turn_count`, `win` and `game_over` all update together after E21;
  - `done` and `busy` are low after E22.
- Fixed latency: 21 cycles from the start edge to the `done` pulse.
- Results hold steady between `done` pulses.

## Configuration
Macro `FEEDBACK_SORTED_EN`:
- Defined: pegs are packed so that blacks occupy `peg0..` first, then whites, then none. This is standard Mastermind, which hides positions.
- Undefined: `peg[i]` reports guess slot i.
- `blacks` and `whites` are identical in both builds.

## Structure
- Shared `mastermind_pkg` holds:
  - `PEG_NONE`, `PEG_WHITE`, `PEG_BLACK`;
  - `COLOR_W`;
  - the FSM state typedef.
- Sub-module `peg_packer` (combinational, instantiated only under `FEEDBACK_SORTED_EN`) converts `blacks`/`whites` into the packed peg vector.

## Test plan
- Code 1,2,3,4 with guess 1,2,3,4 → `done` 21 cycles after start; blacks=4, whites=0, pegs all 10, `win`=1, `game_over`=1, `turn_count`=1.
- Code 1,1,2,3 with guess 1,2,1,1 → blacks=1, whites=2.
  - Unsorted pegs 10,01,01,00.
  - Sorted pegs 10,01,01,00.
- Code 0,1,2,3 with guess 4,4,4,4, scored 8 times → `game_over`=1 after the 8th `done` and `turn_count`=8. A 9th `start` produces no `busy` and no `done`.
- Code 3,2,1,0 with guess 0,1,2,3, sorted build → blacks=0, whites=4, pegs 01,01,01,01. Unsorted pegs are the same.
- `new_game` 10 cycles after start → `busy` low next edge, no `done`, all outputs 0. `start` on that same edge is ignored.
- `start` re-pulsed while busy → exactly one `done`, and `turn_count` increments by 1. `reset` asserted at cycle 7 → all outputs 0 immediately, and no `done` follows.
